div_sequencer: RTL and testbench

//  Multicycle sequencer for the iterative signed divider. Accepts a DIV request from the main control unit,

---
 rtl/div_seq_pkg.sv | 19 +
 rtl/div_seq_if.sv | 35 +++
 rtl/div_iter_counter.sv | 36 +++
 rtl/div_sequencer.sv | 123 ++++++++++++
 tb/tb_div_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and defaults for the iterative divider sequencer.
// Holds the FSM state enum and the default iteration geometry.
package div_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        DONE,
        EXC
    } state_e;

    localparam int DATA_W_DEF     = 32;
    localparam int DIV_CYCLES_DEF = 32;
    // Must satisfy 2**CNT_W > DIV_CYCLES.
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/div_seq_if.sv
// Bundle between control unit, sequencer and divider engine.
// slave:  sequencer side (request in, status/results/engine drive out).
// master: control unit + divider engine side.
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              eng_ctrl;
    logic [DATA_W-1:0] eng_a;
    logic [DATA_W-1:0] eng_b;
    logic [DATA_W-1:0] eng_quot;
    logic [DATA_W-1:0] eng_rem;
    logic              eng_zero;

    modport slave (
        input  start, opa, opb,
        input  eng_quot, eng_rem, eng_zero,
        output busy, done, div_zero, hi, lo,
        output eng_ctrl, eng_a, eng_b
    );

    modport master (
        output start, opa, opb,
        output eng_quot, eng_rem, eng_zero,
        input  busy, done, div_zero, hi, lo,
        input  eng_ctrl, eng_a, eng_b
    );
endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider RUN phase.
// Ports: clk, rst_n (async active-low), clr (sync clear),
//        en (increment), last (count == DIV_CYCLES-1).
module div_iter_counter #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(DIV_CYCLES - 1));

endmodule

// File: rtl/div_sequencer.sv
// Multicycle sequencer for the iterative signed divider.
// Ports: clk, reset (async active-low), bus (div_seq_if.slave):
//   start/opa/opb request; busy/done/div_zero status; hi (rem), lo (quot);
//   eng_ctrl/eng_a/eng_b to divider; eng_quot/eng_rem/eng_zero from it.
// Option: DIV_SEQ_ZERO_SHORTCUT_EN traps a zero divisor at issue.
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     reset,
    div_seq_if.slave bus
);
    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              zero_q;
    logic              ctrl_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              cnt_last;
    logic              cnt_clr;
    logic              cnt_en;

    assign cnt_clr = (state_q == CLEAR);
    assign cnt_en  = (state_q == RUN);

    div_iter_counter #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            ctrl_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            // done/div_zero are single-cycle pulses by default.
            done_q <= 1'b0;
            zero_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE, EXC: begin
                    busy_q <= 1'b0;
                    ctrl_q <= 1'b0;
                    if (bus.start) begin
                        a_q <= bus.opa;
                        b_q <= bus.opb;
`ifdef DIV_SEQ_ZERO_SHORTCUT_EN
                        if (bus.opb == '0) begin
                            state_q <= EXC;
                            zero_q  <= 1'b1;
                        end else begin
                            state_q <= CLEAR;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CLEAR: begin
                    state_q <= RUN;
                    ctrl_q  <= 1'b1;
                end
                RUN: begin
                    // Zero flag beats the count check.
                    if (bus.eng_zero) begin
                        state_q <= EXC;
                        zero_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ctrl_q  <= 1'b0;
                    end else if (cnt_last) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    hi_q    <= bus.eng_rem;
                    lo_q    <= bus.eng_quot;
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ctrl_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ctrl_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.eng_ctrl = ctrl_q;
    assign bus.eng_a    = a_q;
    assign bus.eng_b    = b_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer with a behavioural divider engine.
// Directed cases plus random operands checked against signed arithmetic.
module tb_div_sequencer;
    localparam int DW = 32;
    localparam int NC = 32;
`ifdef DIV_SEQ_ZERO_SHORTCUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 4;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   en_cnt = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    div_seq_if #(.DATA_W(DW)) bus();

    div_sequencer #(
        .DATA_W     (DW),
        .DIV_CYCLES (NC),
        .CNT_W      (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Divider engine: result appears only after NC enabled edges,
    // garbage before that, zero flag after the first enabled edge.
    always @(posedge clk) begin
        if (!bus.eng_ctrl) begin
            en_cnt       <= 0;
            bus.eng_zero <= 1'b0;
            bus.eng_quot <= 32'hDEADBEEF;
            bus.eng_rem  <= 32'hBADC0DE5;
        end else begin
            en_cnt       <= en_cnt + 1;
            bus.eng_zero <= (bus.eng_b == '0);
            if (en_cnt == NC - 1 && bus.eng_b != '0) begin
                bus.eng_quot <= $signed(bus.eng_a) / $signed(bus.eng_b);
                bus.eng_rem  <= $signed(bus.eng_a) % $signed(bus.eng_b);
            end
        end
    end

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] xlo, input logic [31:0] xhi,
                           input bit zero, input int poke);
        int cyc;
        bit seen;
        bus.start = 1'b1;
        bus.opa = a;
        bus.opb = b;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.start = 1'b0;
                if (!zero) chk("busy", 32'(bus.busy), 32'd1);
            end
            if (poke != 0 && cyc == poke) begin
                bus.start = 1'b1;
                bus.opa = 32'd50;
                bus.opb = 32'd5;
            end
            if (poke != 0 && cyc == poke + 1) begin
                bus.start = 1'b0;
                chk("ign_a", bus.eng_a, a);
                chk("ign_b", bus.eng_b, b);
            end
            if (bus.done || bus.div_zero) seen = 1;
        end
        if (zero) begin
            chk("zero_lat", 32'(cyc), 32'(ZLAT));
            chk("zero_flags", 32'({bus.done, bus.div_zero}), 32'd1);
        end else begin
            chk("done_lat", 32'(cyc), 32'(NC + 3));
            chk("done_flags", 32'({bus.done, bus.div_zero}), 32'd2);
            exp_lo = xlo;
            exp_hi = xhi;
        end
        chk("lo", bus.lo, exp_lo);
        chk("hi", bus.hi, exp_hi);
    endtask

    task automatic post_chk();
        @(negedge clk);
        chk("pulse_end", 32'({bus.done, bus.div_zero, bus.busy}), 32'd0);
        chk("lo_hold", bus.lo, exp_lo);
        chk("hi_hold", bus.hi, exp_hi);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_flags"},
            32'({bus.busy, bus.done, bus.div_zero, bus.eng_ctrl}), 32'd0);
        chk({tag, "_hi"}, bus.hi, 32'd0);
        chk({tag, "_lo"}, bus.lo, 32'd0);
        chk({tag, "_a"}, bus.eng_a, 32'd0);
        chk({tag, "_b"}, bus.eng_b, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] r;
        int dcnt;
        bus.start = 1'b0;
        bus.opa = '0;
        bus.opb = '0;
        @(negedge clk);
        @(negedge clk);
        reset_chk("rst");
        reset = 1'b1;
        @(negedge clk);

        run_div(32'd7, 32'd2, 32'd3, 32'd1, 0, 0);
        post_chk();
        run_div(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0);
        post_chk();
        run_div(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 0, 0);
        post_chk();
        run_div(32'd5, 32'd0, 32'd0, 32'd0, 1, 0);
        post_chk();
        run_div(32'd9, 32'd4, 32'd2, 32'd1, 0, 12);
        run_div(32'd50, 32'd5, 32'd10, 32'd0, 0, 0);
        post_chk();

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = 32'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (ra == 32'h80000000) ra = 32'd1;
            r = ref_div(ra, rb);
            run_div(ra, rb, r[31:0], r[63:32], 0, 0);
            post_chk();
        end
        run_div($urandom, 32'd0, 32'd0, 32'd0, 1, 0);
        post_chk();

        bus.start = 1'b1;
        bus.opa = 32'd1000;
        bus.opb = 32'd3;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        reset_chk("abort");
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.div_zero) dcnt++;
        end
        chk("no_done_after_abort", 32'(dcnt), 32'd0);
        run_div(32'd1000, 32'd3, 32'd333, 32'd1, 0, 0);
        post_chk();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
